bcd_scan_8digit: RTL and testbench
==================================

Name: bcd_scan_8digit

Overview:
- Upstream driver for the BCD-to-7-segment decoder in the 8-display board design.
- Holds an 8-digit packed BCD value and time-multiplexes one digit at a time onto the decoder inputs (bcd, enable, seg7all_on).
- Drives the active-low common-anode selects, with a blanking guard interval between digits to suppress ghosting.
- Double-buffers the display value so updates never tear mid-frame.

Parameters:
- DIGIT_CYCLES, 50000, clock cycles each digit is lit (SHOW interval); must be >= 1.
- BLANK_CYCLES, 500, clock cycles of all-anodes-off guard after each digit; 0 disables the guard.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- display_en  input  1  1 = scanning active; 0 = display dark.
- digits_in  input  32  packed BCD; [3:0] = digit 0 (rightmost), [31:28] = digit 7.
- load  input  1  single-cycle strobe; captures digits_in.
- lead_zero_blank  input  1  1 = suppress leading zeros.
- lamp_test  input  1  1 = light all segments on every scanned digit.
- bcd  output  4  current digit value to decoder.
- enable  output  1  decoder enable.
- seg7all_on  output  1  decoder all-segments-on.
- an  output  8  anode selects, active-low, one-hot-low; an[i] selects digit i.
- digit_idx  output  3  index of the digit currently lit.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, sync release): an=8'hFF, bcd=0, enable=0, seg7all_on=0, digit_idx=0, frame_done=0, active and pending registers = 0, pend flag = 0, state = IDLE.
- All outputs are registered.
- Counter width: $clog2(max(DIGIT_CYCLES, BLANK_CYCLES, 2)).
- States:
  - IDLE: an=FF, enable=0, seg7all_on=0. Enter SHOW with digit_idx=0 and counter=0 on the first cycle display_en=1.
  - SHOW: an[digit_idx]=0, all other bits 1. bcd = active[4*digit_idx +: 4]. Lasts exactly DIGIT_CYCLES cycles, then goes to BLANK, or straight to the next SHOW if BLANK_CYCLES=0.
  - BLANK: an=FF, enable=0. Lasts BLANK_CYCLES cycles, then SHOW of digit_idx+1 (mod 8).
- display_en=0 in any state: next cycle is IDLE. Scan position is not retained; re-enable always restarts at digit 0.
- Frame boundary is the transition out of digit 7 (end of its BLANK, or end of its SHOW when BLANK_CYCLES=0). In that same cycle:
  - frame_done=1 for one cycle.
  - If pend=1, active <= pending and pend is cleared.
- load:
  - pending <= digits_in and pend <= 1.
  - Repeated loads within a frame: last one wins.
  - load coincident with the frame boundary: active <= digits_in directly and pend is cleared.
  - load while IDLE: active <= digits_in immediately and no pend is set.
- enable during SHOW: 1 unless blanked by lead_zero_blank. Digit i (i = 1..7) is blanked when it and all higher digits of active equal 0. Digit 0 is never blanked (value 0 shows "0").
- lamp_test=1: seg7all_on=1 and enable=1 in SHOW for every digit; this overrides leading-zero blanking. In BLANK and IDLE, seg7all_on=0.
- Non-BCD nibbles (A–F) pass through unchanged; decoding them is the decoder's concern.
- lead_zero_blank and lamp_test are sampled every cycle, not only at frame boundaries.
- Reset mid-frame: immediate return to reset values. Any pending update is discarded.

Test Plan:
- Reset and basic scan (DIGIT_CYCLES=4, BLANK_CYCLES=1):
  - Stimulus: load 32'h87654321, display_en=1.
  - Required: an sequence FE(4 cycles), FF(1), FD(4), FF(1) … 7F(4), FF(1). bcd = 1, 2 … 8 during the corresponding SHOW. frame_done pulses every 40 cycles.
- Tear-free update:
  - Stimulus: load 32'h11111111 while digit 3 is lit in a 32'h87654321 frame.
  - Required: digits 4–7 still show 5–8. The next frame shows all 1s. frame_done coincides with the commit.
- Load collision:
  - Stimulus: load 32'h22222222 mid-frame, then load 32'h33333333 exactly on the frame-boundary cycle.
  - Required: the next frame shows all 3s; pend=0 afterwards.
- Leading-zero blanking:
  - Stimulus: active 32'h00000407, lead_zero_blank=1.
  - Required: enable=0 for digits 7..3; enable=1 for digits 2 ("4"), 1 ("0"), 0 ("7").
  - Stimulus: active 32'h00000000.
  - Required: only digit 0 is enabled.
- Lamp test and BLANK_CYCLES=0:
  - Stimulus: lamp_test=1 with active 32'h00000000 and lead_zero_blank=1.
  - Required: all 8 digits show enable=1, seg7all_on=1.
  - Stimulus: BLANK_CYCLES=0.
  - Required: an never reads FF between digits while scanning.
- Disable and reset mid-operation:
  - Stimulus: display_en=0 during digit 5.
  - Required: next cycle an=FF, enable=0. On re-enable, digit 0 is lit.
  - Stimulus: rst_n=0 asynchronously mid-SHOW.
  - Required: an=FF and bcd=0 without waiting for a clock edge; pending update lost.

Source files
------------

// File: rtl/bcd_scan_if.sv
// bcd_scan_if: control inputs and decoder/anode outputs of the 8-digit BCD scanner
interface bcd_scan_if;
  logic        display_en;
  logic [31:0] digits_in;
  logic        load;
  logic        lead_zero_blank;
  logic        lamp_test;
  logic [3:0]  bcd;
  logic        enable;
  logic        seg7all_on;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_done;
  modport master (output display_en, digits_in, load, lead_zero_blank, lamp_test,
                  input bcd, enable, seg7all_on, an, digit_idx, frame_done);
  modport slave  (input display_en, digits_in, load, lead_zero_blank, lamp_test,
                  output bcd, enable, seg7all_on, an, digit_idx, frame_done);
endinterface

// File: rtl/bcd_scan_8digit.sv
// bcd_scan_8digit: double-buffered 8-digit BCD multiplex scanner with blanking guard
module bcd_scan_8digit #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst_n,
  bcd_scan_if.slave bus
);
  localparam int MX = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MX > 2 ? MX : 2);
  localparam logic [CW-1:0] DL = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  state_t state, n_state;
  logic [2:0] idx, n_idx;
  logic [CW-1:0] cnt, n_cnt;
  logic [31:0] active, n_active, pending, n_pending, upper;
  logic pend, n_pend, fb, show;
  // next scan position, frame boundary and buffer commit; outputs are registered from these
  always_comb begin
    n_state = state;
    n_idx = idx;
    n_cnt = cnt + 1'b1;
    fb = 1'b0;
    if (!bus.display_en) begin
      n_state = IDLE;
      n_idx = 3'd0;
      n_cnt = '0;
    end else if (state == IDLE) begin
      n_state = SHOW;
      n_idx = 3'd0;
      n_cnt = '0;
    end else if (state == SHOW && cnt == DL) begin
      n_cnt = '0;
      if (BLANK_CYCLES == 0) begin
        n_idx = idx + 3'd1;
        fb = idx == 3'd7;
      end else n_state = BLANK;
    end else if (state == BLANK && cnt == BL) begin
      n_state = SHOW;
      n_cnt = '0;
      n_idx = idx + 3'd1;
      fb = idx == 3'd7;
    end
    n_active = active;
    n_pending = pending;
    n_pend = pend;
    if (bus.load && state == IDLE) n_active = bus.digits_in;
    else if (bus.load && fb) begin
      n_active = bus.digits_in;
      n_pend = 1'b0;
    end else if (bus.load) begin
      n_pending = bus.digits_in;
      n_pend = 1'b1;
    end else if (fb && pend) begin
      n_active = pending;
      n_pend = 1'b0;
    end
    show = n_state == SHOW;
    upper = n_active >> {n_idx, 2'b00};
  end
  // scan state, display buffers and registered decoder/anode outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= '0;
      active <= '0;
      pending <= '0;
      pend <= 1'b0;
      bus.an <= 8'hFF;
      bus.bcd <= 4'd0;
      bus.enable <= 1'b0;
      bus.seg7all_on <= 1'b0;
      bus.digit_idx <= 3'd0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= n_state;
      idx <= n_idx;
      cnt <= n_cnt;
      active <= n_active;
      pending <= n_pending;
      pend <= n_pend;
      bus.an <= show ? ~(8'b1 << n_idx) : 8'hFF;
      bus.bcd <= show ? upper[3:0] : 4'd0;
      bus.enable <= show && (bus.lamp_test || !bus.lead_zero_blank || n_idx == 3'd0 || upper != 32'd0);
      bus.seg7all_on <= show && bus.lamp_test;
      bus.digit_idx <= n_idx;
      bus.frame_done <= fb;
    end
  end
endmodule

// File: tb/tb_bcd_scan_8digit.sv
// tb_bcd_scan_8digit: random and directed checks of two scanner configurations against a timeline model
module tb_bcd_scan_8digit;
  logic clk = 1'b0, rst_n = 1'b0, de = 1'b0, load = 1'b0, lzb = 1'b0, lt = 1'b0;
  logic [31:0] din = '0;
  int errors = 0, checks = 0;
  bcd_scan_if ia ();
  bcd_scan_if ib ();
  assign ia.display_en = de;
  assign ia.digits_in = din;
  assign ia.load = load;
  assign ia.lead_zero_blank = lzb;
  assign ia.lamp_test = lt;
  assign ib.display_en = de;
  assign ib.digits_in = din;
  assign ib.load = load;
  assign ib.lead_zero_blank = lzb;
  assign ib.lamp_test = lt;
  bcd_scan_8digit #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  bcd_scan_8digit #(.DIGIT_CYCLES(3), .BLANK_CYCLES(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  always #5 clk = ~clk;
  logic [7:0] an_o[2];
  logic [3:0] bcd_o[2];
  logic [2:0] idx_o[2];
  logic en_o[2], s7_o[2], fd_o[2];
  assign an_o[0] = ia.an;
  assign an_o[1] = ib.an;
  assign bcd_o[0] = ia.bcd;
  assign bcd_o[1] = ib.bcd;
  assign idx_o[0] = ia.digit_idx;
  assign idx_o[1] = ib.digit_idx;
  assign en_o[0] = ia.enable;
  assign en_o[1] = ib.enable;
  assign s7_o[0] = ia.seg7all_on;
  assign s7_o[1] = ib.seg7all_on;
  assign fd_o[0] = ia.frame_done;
  assign fd_o[1] = ib.frame_done;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask
  // timeline model: t = cycles since the scan started (-1 when dark); digit and phase follow from t
  int dc[2] = '{4, 3};
  int per[2] = '{5, 3};
  int mt[2];
  logic [31:0] ma[2], mp[2];
  bit mf[2], mfb[2], mz[2], ml[2];
  always @(posedge clk or negedge rst_n) begin
    int nt;
    bit fb;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mt[k] = -1; ma[k] = 0; mp[k] = 0; mf[k] = 0; mfb[k] = 0; mz[k] = 0; ml[k] = 0;
      end else begin
        nt = !de ? -1 : (mt[k] < 0 ? 0 : mt[k] + 1);
        fb = nt > 0 && nt % (8 * per[k]) == 0;
        if (load && mt[k] < 0) ma[k] = din;
        else if (load && fb) begin ma[k] = din; mf[k] = 0; end
        else if (load) begin mp[k] = din; mf[k] = 1; end
        else if (fb && mf[k]) begin ma[k] = mp[k]; mf[k] = 0; end
        mt[k] = nt; mfb[k] = fb; mz[k] = lzb; ml[k] = lt;
      end
    end
  end
  // compare every cycle, away from the clock edge
  always @(negedge clk) begin
    int d;
    bit sh, en;
    for (int k = 0; k < 2; k++) begin
      d = mt[k] < 0 ? 0 : (mt[k] / per[k]) % 8;
      sh = mt[k] >= 0 && (mt[k] % per[k]) < dc[k];
      en = sh && (ml[k] || !mz[k] || d == 0 || (ma[k] >> (4 * d)) != 0);
      chk($sformatf("an%0d", k), an_o[k], sh ? ~(32'd1 << d) & 32'hFF : 32'hFF);
      chk($sformatf("bcd%0d", k), bcd_o[k], sh ? (ma[k] >> (4 * d)) & 32'hF : 0);
      chk($sformatf("idx%0d", k), idx_o[k], d);
      chk($sformatf("enable%0d", k), en_o[k], en);
      chk($sformatf("seg7all%0d", k), s7_o[k], sh && ml[k]);
      chk($sformatf("frame_done%0d", k), fd_o[k], mfb[k]);
    end
  end
  task automatic wait_a(input logic [2:0] i, input logic [7:0] a);
    int n = 0;
    while (!(ia.digit_idx == i && ia.an == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_timeout", 1, 0);
  endtask
  task automatic load_idle(input logic [31:0] v);
    de = 0;
    @(negedge clk);
    load = 1; din = v;
    @(negedge clk);
    load = 0; de = 1;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", ia.an, 8'hFF);
    chk("reset_bcd", ia.bcd, 0);
    rst_n = 1;
    load_idle(32'h87654321);
    chk("t0_an", ia.an, 8'hFE);
    chk("t0_bcd", ia.bcd, 1);
    repeat (3) @(negedge clk);
    chk("b_t3_an", ib.an, 8'hFD);
    @(negedge clk);
    chk("t4_blank", ia.an, 8'hFF);
    @(negedge clk);
    chk("t5_an", ia.an, 8'hFD);
    chk("t5_bcd", ia.bcd, 2);
    repeat (35) @(negedge clk);
    chk("t40_fd", ia.frame_done, 1);
    chk("t40_an", ia.an, 8'hFE);
    wait_a(3, 8'hF7);
    load = 1; din = 32'h11111111;
    @(negedge clk);
    load = 0;
    wait_a(5, 8'hDF);
    chk("tear_bcd", ia.bcd, 6);
    wait_a(0, 8'hFE);
    chk("commit_fd", ia.frame_done, 1);
    chk("commit_bcd", ia.bcd, 1);
    wait_a(4, 8'hEF);
    load = 1; din = 32'h22222222;
    @(negedge clk);
    load = 0;
    wait_a(7, 8'hFF);
    load = 1; din = 32'h33333333;
    @(negedge clk);
    load = 0;
    chk("coll_fd", ia.frame_done, 1);
    chk("coll_bcd", ia.bcd, 3);
    repeat (40) @(negedge clk);
    chk("coll_next_bcd", ia.bcd, 3);
    lzb = 1;
    load_idle(32'h00000407);
    chk("lzb_d0", ia.enable, 1);
    repeat (5) @(negedge clk);
    chk("lzb_d1", ia.enable, 1);
    repeat (5) @(negedge clk);
    chk("lzb_d2", ia.enable, 1);
    repeat (5) @(negedge clk);
    chk("lzb_d3", ia.enable, 0);
    lt = 1;
    @(negedge clk);
    chk("lamp_en", ia.enable, 1);
    chk("lamp_s7", ia.seg7all_on, 1);
    lt = 0;
    load_idle(32'h00000000);
    chk("zero_d0", ia.enable, 1);
    repeat (5) @(negedge clk);
    chk("zero_d1", ia.enable, 0);
    lzb = 0;
    wait_a(5, 8'hDF);
    de = 0;
    @(negedge clk);
    chk("dis_an", ia.an, 8'hFF);
    chk("dis_en", ia.enable, 0);
    de = 1;
    @(negedge clk);
    chk("reen_an", ia.an, 8'hFE);
    load_idle(32'h55555555);
    wait_a(2, 8'hFB);
    load = 1; din = 32'h66666666;
    @(negedge clk);
    load = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_an", ia.an, 8'hFF);
    chk("arst_bcd", ia.bcd, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("arst_restart_bcd", ia.bcd, 0);
    repeat (40) @(negedge clk);
    chk("arst_lost_bcd", ia.bcd, 0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 2) de = ~de;
      if ($urandom_range(0, 99) < 8) lzb = ~lzb;
      if ($urandom_range(0, 99) < 4) lt = ~lt;
      load = $urandom_range(0, 99) < 4;
      for (int j = 0; j < 8; j++) din[4 * j +: 4] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (i % 300 == 0) de = 1;
      @(negedge clk);
    end
    load = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
